// File: rtl/musa_pkg.sv
// Shared encodings for the MUSA EX stage: opcodes, functs, ALU control codes and issue FSM states.
package musa_pkg;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpSubi  = 6'h09;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;

    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnNot = 6'h27;
    localparam logic [5:0] FnMul = 6'h02;
    localparam logic [5:0] FnDiv = 6'h01;
    localparam logic [5:0] FnCmp = 6'h2A;

    localparam logic [2:0] CtrlAddi  = 3'b000;
    localparam logic [2:0] CtrlSubi  = 3'b001;
    localparam logic [2:0] CtrlRtype = 3'b010;
    localparam logic [2:0] CtrlAndi  = 3'b011;
    localparam logic [2:0] CtrlOri   = 3'b100;

    typedef enum logic [1:0] {LatOne, LatMul, LatDiv} lat_class_e;

    typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

endpackage

// File: rtl/issue_decode.sv
// Combinational decode of one instruction into ALU controls, operands, destination and latency.
module issue_decode
    import musa_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    output logic [2:0]  ctrl_o,
    output logic [5:0]  func_o,
    output logic [31:0] data_a_o,
    output logic [31:0] data_b_o,
    output logic [4:0]  dest_o,
    output lat_class_e  lat_o,
    output logic        legal_o,
    output logic        cmp_o,
    output logic        div_o
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic        unused_rs;

    assign opcode    = instr_i[31:26];
    assign funct     = instr_i[5:0];
    assign imm       = instr_i[15:0];
    // rs is already resolved to rs_data upstream
    assign unused_rs = ^instr_i[25:21];

    always_comb begin
        ctrl_o   = '0;
        func_o   = '0;
        data_a_o = rs_data_i;
        data_b_o = rt_data_i;
        dest_o   = instr_i[20:16];
        lat_o    = LatOne;
        legal_o  = 1'b0;
        cmp_o    = 1'b0;
        div_o    = 1'b0;
        unique case (opcode)
            OpRtype: begin
                ctrl_o = CtrlRtype;
                func_o = funct;
                dest_o = instr_i[15:11];
                unique case (funct)
                    FnAdd, FnSub, FnAnd, FnOr, FnNot: legal_o = 1'b1;
                    FnCmp: begin
                        legal_o = 1'b1;
                        cmp_o   = 1'b1;
                    end
                    FnMul: begin
                        legal_o = 1'b1;
                        lat_o   = LatMul;
                    end
                    FnDiv: begin
                        legal_o = 1'b1;
                        div_o   = 1'b1;
                        lat_o   = LatDiv;
                    end
                    default: legal_o = 1'b0;
                endcase
            end
            OpAddi: begin
                ctrl_o   = CtrlAddi;
                data_b_o = {{16{imm[15]}}, imm};
                legal_o  = 1'b1;
            end
            OpSubi: begin
                ctrl_o   = CtrlSubi;
                data_b_o = {{16{imm[15]}}, imm};
                legal_o  = 1'b1;
            end
            OpAndi: begin
                ctrl_o   = CtrlAndi;
                data_b_o = {16'h0000, imm};
                legal_o  = 1'b1;
            end
            OpOri: begin
                ctrl_o   = CtrlOri;
                data_b_o = {16'h0000, imm};
                legal_o  = 1'b1;
            end
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// EX-stage issue controller: holds ALU inputs for the op latency, captures result/flags and
// presents write-back data over a valid/ready handshake.
module alu_issue_ctrl
    import musa_pkg::*;
#(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [31:0] alu_data_a,
    output logic [31:0] alu_data_b,
    output logic [2:0]  alu_control,
    output logic [5:0]  alu_func,
    input  logic [31:0] alu_result,
    input  logic [2:0]  alu_flag,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic [2:0]  flag_reg,
    output logic        illegal,
    output logic        div_zero
);

    localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CntW   = $clog2(MaxLat + 1);

    logic [2:0]      dec_ctrl;
    logic [5:0]      dec_func;
    logic [31:0]     dec_a;
    logic [31:0]     dec_b;
    logic [4:0]      dec_dest;
    lat_class_e      dec_lat;
    logic            dec_legal;
    logic            dec_cmp;
    logic            dec_div;
    logic [CntW-1:0] lat_init;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [4:0]      dest_q;
    logic            cmp_q;

    issue_decode u_decode (
        .instr_i   (instr),
        .rs_data_i (rs_data),
        .rt_data_i (rt_data),
        .ctrl_o    (dec_ctrl),
        .func_o    (dec_func),
        .data_a_o  (dec_a),
        .data_b_o  (dec_b),
        .dest_o    (dec_dest),
        .lat_o     (dec_lat),
        .legal_o   (dec_legal),
        .cmp_o     (dec_cmp),
        .div_o     (dec_div)
    );

    // Counter counts down to the capture edge, so it starts one below the hold window.
    always_comb begin
        lat_init = '0;
        unique case (dec_lat)
            LatMul:  lat_init = CntW'(MUL_LAT - 1);
            LatDiv:  lat_init = CntW'(DIV_LAT - 1);
            default: lat_init = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            dest_q      <= '0;
            cmp_q       <= 1'b0;
            instr_ready <= 1'b0;
            alu_data_a  <= '0;
            alu_data_b  <= '0;
            alu_control <= '0;
            alu_func    <= '0;
            wb_valid    <= 1'b0;
            wb_reg      <= '0;
            wb_data     <= '0;
            flag_reg    <= '0;
            illegal     <= 1'b0;
            div_zero    <= 1'b0;
        end else begin
            illegal  <= 1'b0;
            div_zero <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    instr_ready <= 1'b1;
                    if (instr_valid && instr_ready) begin
                        if (!dec_legal) begin
                            illegal <= 1'b1;
                        end else if (dec_div && rt_data == '0) begin
                            div_zero <= 1'b1;
                            wb_data  <= '0;
                            if (dec_dest != '0) begin
                                wb_valid    <= 1'b1;
                                wb_reg      <= dec_dest;
                                instr_ready <= 1'b0;
                                state_q     <= StWb;
                            end
                        end else begin
                            alu_data_a  <= dec_a;
                            alu_data_b  <= dec_b;
                            alu_control <= dec_ctrl;
                            alu_func    <= dec_func;
                            cnt_q       <= lat_init;
                            dest_q      <= dec_dest;
                            cmp_q       <= dec_cmp;
                            instr_ready <= 1'b0;
                            state_q     <= StExec;
                        end
                    end
                end
                StExec: begin
                    if (cnt_q == '0) begin
                        wb_data  <= alu_result;
                        flag_reg <= alu_flag;
                        if (cmp_q || dest_q == '0) begin
                            instr_ready <= 1'b1;
                            state_q     <= StIdle;
                        end else begin
                            wb_valid <= 1'b1;
                            wb_reg   <= dest_q;
                            state_q  <= StWb;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StWb: begin
                    if (wb_ready) begin
                        wb_valid    <= 1'b0;
                        instr_ready <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Issue-side controller for the EX-stage ALU: accepts one decoded-stage instruction plus operands over a valid/ready handshake and drives the ALU's `data_a`, `data_b`, `alu_control` and `func` inputs. It holds those inputs stable for the operation's latency: one cycle for add, sub, and, or, not and compare; longer, configurable windows for MUL and DIV. It then captures `result` and `flag`, maintains the architectural flag register used by BRFL, and presents write-back data over a second valid/ready handshake. It sits between the ID/EX pipeline register and write-back.

## Interface
- `MUL_LAT`, default 4: cycles ALU inputs are held for MUL (≥1).
- `DIV_LAT`, default 8: cycles ALU inputs are held for DIV (≥1).
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `instr_valid` in 1: instruction and operands valid.
- `instr_ready` out 1: block can accept an instruction.
- `instr` in 32: instruction word. Fields: opcode [31:26], rd [15:11], rt [20:16], imm [15:0], funct [5:0].
- `rs_data`, `rt_data` in 32: register operands.
- `alu_data_a`, `alu_data_b` out 32: to ALU.
- `alu_control` out 3: to ALU.
- `alu_func` out 6: to ALU (funct).
- `alu_result` in 32; `alu_flag` in 3: from ALU.
- `wb_valid` out 1; `wb_ready` in 1; `wb_reg` out 5; `wb_data` out 32: write-back port.
- `flag_reg` out 3: architectural flags.
- `illegal` out 1: one-cycle pulse on an undecodable instruction.
- `div_zero` out 1: one-cycle pulse on DIV with a zero divisor.

## Operation
- FSM states: IDLE, EXEC, WB.
- **IDLE**
  - `instr_ready`=1.
  - On `instr_valid`, register the operands and the decode result, load the latency counter, and go to EXEC.
- **Decode**
  - opcode 6'h00 (R-type): `alu_control`=3'b010, `alu_func`=funct, a=rs_data, b=rt_data, dest=rd.
  - Accepted funct values: ADD 6'h20, SUB 6'h22, AND 6'h24, OR 6'h25, NOT 6'h27, MUL 6'h02, DIV 6'h01, CMP 6'h2A.
  - I-type: dest=rt, `alu_func`=0.
    - ADDI 6'h08 → ctrl 3'b000, sign-extended imm.
    - SUBI 6'h09 → 3'b001, sign-extended imm.
    - ANDI 6'h0C → 3'b011, zero-extended imm.
    - ORI 6'h0D → 3'b100, zero-extended imm.
  - Any other opcode or funct: pulse `illegal` in the cycle after acceptance, stay in IDLE, drive no ALU.
- **EXEC**
  - ALU outputs come straight from registers and are stable for the whole state.
  - Counter starts at lat−1 (lat = 1, MUL_LAT or DIV_LAT).
  - When the counter reaches 0: capture `alu_result` into `wb_data` and `alu_flag` into `flag_reg`.
  - CMP: updates `flag_reg` only, then returns to IDLE with no write-back.
  - All other ops go to WB.
- **DIV, rt_data==0**
  - Skip EXEC: `div_zero` pulses, `wb_data`=0, `flag_reg` unchanged, go to WB.
- **WB**
  - `wb_valid`=1, with `wb_reg`/`wb_data` stable until `wb_valid && wb_ready`, then go to IDLE.
  - dest==0: no write-back; EXEC returns straight to IDLE.
- `flag_reg` updates only from completed non-DIV-by-zero ops (all ops capture flags; CMP exists purely for flags).

## Timing
- Reset values:
  - State IDLE.
  - `instr_ready`=0 during the reset cycle, 1 on the following cycle.
  - All ALU outputs 0.
  - `wb_valid`=0, `wb_reg`=0, `wb_data`=0, `flag_reg`=0, `illegal`=0, `div_zero`=0.
- Acceptance at edge t0: EXEC runs during cycles t0+1 … t0+lat. Capture happens at edge t0+lat, and `wb_valid` is high from then on.
- Throughput with `wb_ready` tied high: one instruction every lat+2 cycles (instr_ready is low in EXEC and WB).
- `instr_ready` is low in EXEC and WB; `instr_valid` in those states is ignored, not queued.
- `wb_ready` low holds WB indefinitely; outputs stay frozen.
- Reset mid-EXEC or mid-WB: state is abandoned, no write-back occurs, and outputs return to reset values on the next cycle.

## Structure
- Shared package `musa_pkg` holds:
  - Opcode and funct constants, as sized literals.
  - `alu_control` encodings.
  - The FSM state enum.
- One natural sub-module: `issue_decode`, combinational. It maps `instr`/`rs_data`/`rt_data` to ctrl, func, a, b, dest, latency class and legal.

## Test plan
- ADD, rs=5, rt=7, rd=3, `wb_ready`=1 → `wb_valid` one cycle after acceptance, `wb_reg`=3, `wb_data`=12, then `instr_ready`=1.
- ADDI rt=4, imm=16'hFFFF, rs=10 → `alu_data_b`=32'hFFFFFFFF, `wb_data`=9. ORI imm=16'h8000 → b=32'h00008000.
- MUL 6×7, MUL_LAT=4 → ALU inputs held 4 cycles, `wb_data`=42 at 4 cycles after acceptance; `instr_valid` pulsed during EXEC is ignored.
- DIV 100/0 → `div_zero` pulse, `wb_data`=0, `flag_reg` unchanged. DIV 100/7 → `wb_data`=14 after 8 cycles.
- CMP → `flag_reg`=`alu_flag` value, no `wb_valid`. Opcode 6'h3F → `illegal` pulse, no ALU activity.
- `wb_ready` held low 5 cycles → `wb_valid`/`wb_data` stable. Reset asserted in EXEC of a MUL → all outputs at reset values next cycle, no write-back.
